// File: rtl/calci_core.sv
// calci_core: 8-bit calculator, single-cycle add/sub, 8-step shift-add multiply and restoring divide
module calci_core #(
    parameter logic [15:0] DIV0_RESULT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [1:0]  ctrl,
    output logic        Stall,
    output logic [15:0] C,
    output logic        Done
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d, c_q, c_d;
    logic        done_q, done_d, stall_q, stall_d;
    logic [8:0]  trial;
    logic [7:0]  diff;
    logic        ge;
    logic [15:0] mstep, dstep;
    // acc holds the product while multiplying, and {remainder, dividend/quotient} while dividing
    assign trial = {acc_q[15:8], acc_q[7]};
    assign ge    = trial >= {1'b0, b_q};
    assign diff  = trial[7:0] - b_q;
    assign mstep = acc_q + (b_q[cnt_q] ? ({8'b0, a_q} << cnt_q) : 16'h0000);
    assign dstep = {ge ? diff : trial[7:0], acc_q[6:0], ge};
    assign Stall = stall_q;
    assign C     = c_q;
    assign Done  = done_q;
    // state and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            c_q     <= 16'd0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end
    // next state: accept in IDLE, otherwise run one iteration and finish on count 7
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (Valid) begin
                a_d   = A;
                b_d   = B;
                cnt_d = 3'd0;
                case (ctrl)
                    2'b00: begin
                        c_d    = {7'b0, {1'b0, A} + {1'b0, B}};
                        done_d = 1'b1;
                    end
                    2'b01: begin
                        c_d    = {8'b0, A} - {8'b0, B};
                        done_d = 1'b1;
                    end
                    2'b10: begin
                        state_d = MUL;
                        acc_d   = 16'd0;
                    end
                    default: begin
                        state_d = DIV;
                        acc_d   = {8'b0, A};
                    end
                endcase
            end
            MUL: begin
                acc_d = mstep;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    c_d     = mstep;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            DIV: begin
                acc_d = dstep;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    c_d     = (b_q == 8'd0) ? DIV0_RESULT : dstep;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        stall_d = state_d != IDLE;
    end
endmodule

// File: tb/tb_calci_core.sv
// tb_calci_core: vector table, corner-case sequences and randomized model check for calci_core
module tb_calci_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Valid = 1'b0;
    logic [7:0]  A = 8'd0, B = 8'd0;
    logic [1:0]  ctrl = 2'd0;
    logic        Stall, Done;
    logic [15:0] C;
    int          checks = 0, errors = 0;

    calci_core dut (.clk(clk), .rst(rst), .Valid(Valid), .A(A), .B(B), .ctrl(ctrl),
                    .Stall(Stall), .C(C), .Done(Done));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        Valid = 1'b1; ctrl = v.op; A = v.a; B = v.b;
        tick();
        Valid = 1'b0; A = 8'($urandom); B = 8'($urandom); ctrl = 2'($urandom);
        n = 0;
        while (!Done && n < 12) begin
            tick();
            n++;
        end
        chk("vec_latency", n, v.lat);
        chk("vec_C", C, v.c);
        chk("vec_stall_at_done", Stall, 1'b0);
        tick();
        chk("vec_done_drop", Done, 1'b0);
        chk("vec_C_hold", C, v.c);
    endtask

    vec_t vecs [12];
    int   m_busy;
    logic [15:0] m_c, m_pend;
    logic m_done;
    bit   seen;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{2'b00, 8'hFF, 8'hFF, 16'h01FE, 0},
            '{2'b01, 8'hFF, 8'hFF, 16'h0000, 0},
            '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 8},
            '{2'b11, 8'hFF, 8'hFF, 16'h0001, 8},
            '{2'b00, 8'd200, 8'd100, 16'd300, 0},
            '{2'b01, 8'd3, 8'd5, 16'hFFFE, 0},
            '{2'b11, 8'd100, 8'd7, 16'h020E, 8},
            '{2'b11, 8'd42, 8'd0, 16'hFFFF, 8},
            '{2'b10, 8'd15, 8'd17, 16'd255, 8},
            '{2'b10, 8'd0, 8'd99, 16'd0, 8},
            '{2'b11, 8'd7, 8'd200, 16'h0700, 8},
            '{2'b10, 8'd128, 8'd2, 16'd256, 8}
        };
        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_C", C, 16'h0000);
        chk("rst_Stall", Stall, 1'b0);
        chk("rst_Done", Done, 1'b0);
        // request while reset is high is ignored, first edge after release accepts
        Valid = 1'b1; ctrl = 2'b00; A = 8'd1; B = 8'd1;
        tick();
        chk("rst_ignore_Done", Done, 1'b0);
        chk("rst_ignore_C", C, 16'h0000);
        rst = 1'b0;
        tick();
        chk("post_rst_Done", Done, 1'b1);
        chk("post_rst_C", C, 16'd2);
        Valid = 1'b0;
        tick();
        foreach (vecs[i]) run_op(vecs[i]);
        // back-to-back add then sub
        Valid = 1'b1; ctrl = 2'b00; A = 8'd200; B = 8'd100;
        tick();
        chk("b2b_add_C", C, 16'd300);
        chk("b2b_add_Done", Done, 1'b1);
        chk("b2b_add_Stall", Stall, 1'b0);
        ctrl = 2'b01; A = 8'd3; B = 8'd5;
        tick();
        chk("b2b_sub_C", C, 16'hFFFE);
        chk("b2b_sub_Done", Done, 1'b1);
        chk("b2b_sub_Stall", Stall, 1'b0);
        // multiply with Valid held high through the stall
        ctrl = 2'b10; A = 8'd15; B = 8'd17;
        tick();
        chk("held_E_Stall", Stall, 1'b1);
        chk("held_E_Done", Done, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                chk("held_busy_Stall", Stall, 1'b1);
                chk("held_busy_Done", Done, 1'b0);
                chk("held_busy_C", C, 16'hFFFE);
            end else begin
                chk("held_done_Done", Done, 1'b1);
                chk("held_done_C", C, 16'd255);
                chk("held_done_Stall", Stall, 1'b0);
            end
        end
        tick();
        chk("held_reaccept_Stall", Stall, 1'b1);
        chk("held_reaccept_Done", Done, 1'b0);
        Valid = 1'b0;
        repeat (8) tick();
        chk("held_second_Done", Done, 1'b1);
        chk("held_second_C", C, 16'd255);
        // reset in the middle of a multiply
        Valid = 1'b1; ctrl = 2'b10; A = 8'd9; B = 8'd9;
        tick();
        Valid = 1'b0;
        repeat (4) tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_C", C, 16'h0000);
        chk("midrst_Stall", Stall, 1'b0);
        chk("midrst_Done", Done, 1'b0);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (Done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 1'b0);
        Valid = 1'b1; ctrl = 2'b00; A = 8'd1; B = 8'd1;
        tick();
        chk("midrst_add_C", C, 16'd2);
        chk("midrst_add_Done", Done, 1'b1);
        Valid = 1'b0;
        // randomized traffic against a transaction-level model
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        m_busy = 0; m_c = 16'h0000; m_pend = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            Valid = 1'($urandom_range(0, 2) != 0);
            ctrl  = 2'($urandom);
            A     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            B     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            m_done = 1'b0;
            if (m_busy == 0) begin
                if (Valid) begin
                    case (ctrl)
                        2'b00: begin m_c = 16'(int'(A) + int'(B)); m_done = 1'b1; end
                        2'b01: begin m_c = 16'(int'(A) - int'(B)); m_done = 1'b1; end
                        2'b10: begin m_pend = 16'(int'(A) * int'(B)); m_busy = 8; end
                        default: begin
                            m_pend = (B == 0) ? 16'hFFFF : {8'(A % B), 8'(A / B)};
                            m_busy = 8;
                        end
                    endcase
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_c = m_pend;
                    m_done = 1'b1;
                end
            end
            tick();
            chk("rnd_C", C, m_c);
            chk("rnd_Done", Done, m_done);
            chk("rnd_Stall", Stall, m_busy != 0);
        end
        Valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calci_core.md
CALCI_CORE -- requirements
Module: calci_core

Interface
REQ-001 Parameter DIV0_RESULT, default 16'hFFFF, value driven on C for a divide by zero.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 Valid  input  1  request present on A, B and ctrl.
REQ-005 A  input  8  operand A, unsigned.
REQ-006 B  input  8  operand B, unsigned.
REQ-007 ctrl  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 Stall  output  1  registered backpressure; high means no request is accepted this cycle.
REQ-009 C  output  16  registered result; holds its value until the next result.
REQ-010 Done  output  1  one-cycle pulse; C is new in this cycle.

Function
REQ-011 Accept rule: a request is accepted on a rising edge where Valid=1 and Stall=0.
REQ-012 On accept, A, B and ctrl are latched; the inputs are don't-care after that edge.
REQ-013 When Stall=1 or Valid=0, the inputs are ignored and there is no side effect.
REQ-014 States: IDLE, MUL, DIV; Stall=0 only in IDLE.
REQ-015 Add, accepted at edge E: C={7'b0,A+B} (9-bit sum, zero-extended) and Done=1, both at E.
REQ-016 Add: state stays IDLE, so back-to-back add/sub accepts every cycle.
REQ-017 Sub, accepted at edge E: C=({8'b0,A}-{8'b0,B}) mod 2^16 (two's complement, e.g. 3-5=16'hFFFE) and Done=1, both at E.
REQ-018 Sub: state stays IDLE.
REQ-019 Mul/div accepted at edge E: state becomes MUL or DIV, Stall=1 and iteration counter=0, all at E.
REQ-020 MUL: shift-add, one multiplier bit per edge, for 8 edges E+1..E+8.
REQ-021 MUL: at E+8, C=A*B (full 16-bit product), Done=1, Stall=0 and state becomes IDLE.
REQ-022 DIV: restoring division, one quotient bit per edge, for 8 edges E+1..E+8.
REQ-023 DIV: at E+8, C={remainder[7:0],quotient[7:0]}, Done=1, Stall=0 and state becomes IDLE.
REQ-024 Mul/div latency is 8 cycles from the accept edge to Done; the next accept is possible at E+9 at the earliest.
REQ-025 Divide by zero (B=0): takes the same 8-cycle timing, and C=DIV0_RESULT at E+8.
REQ-026 Done is deasserted on every edge where no result is produced.
REQ-027 C is unchanged on every edge where no result is produced.
REQ-028 Valid held high while Stall=1 is neither consumed nor queued; it is accepted at the first edge where Stall=0.
REQ-029 Arithmetic edges: A=B=8'hFF gives add 16'h01FE, mul 16'hFE01, div 16'h0001, sub 0.
REQ-030 Counter wrap: the 3-bit iteration counter reaches 7 at E+8, is cleared on the return to IDLE, and no stale count carries into the next operation.

Reset
REQ-031 While rst=1, asynchronously and regardless of clk: state=IDLE, Stall=0, Done=0, C=16'h0000, counter=0.
REQ-032 Operand and partial-result registers are also cleared by rst.
REQ-033 rst asserted mid-MUL/DIV aborts the operation with no Done pulse.
REQ-034 After rst falls, the first rising edge with Valid=1 is accepted.
REQ-035 Valid=1 at the edge where rst deasserts is not accepted if rst is still high at that edge.

Verification
REQ-036 Back-to-back add/sub: add 8'd200+8'd100, then sub 8'd3-8'd5 on consecutive cycles -> C=16'd300 then 16'hFFFE on consecutive Done pulses; Stall stays 0.
REQ-037 Mul with held Valid: 8'd15*8'd17 with Valid held high -> Stall=1 for 8 cycles, Done at E+8 with C=16'd255, the same request re-accepted at E+9.
REQ-038 Div: 8'd100/8'd7 -> Done at E+8, C=16'h020E (remainder 2, quotient 14).
REQ-039 Div by zero: 8'd42/8'd0 -> Done at E+8, C=16'hFFFF, Stall=0 at E+8.
REQ-040 Reset mid-operation: rst pulsed at E+4 of a mul -> C=0, Stall=0 immediately, no Done pulse; a following add 1+1 gives C=16'd2 at its accept edge.
REQ-041 Max operands: A=B=8'hFF for all four ctrl codes -> 16'h01FE, 16'h0000, 16'hFE01, 16'h0001.
